// File: rtl/next_pc_predict_if.sv
// Fetch-PC unit bus: front-end inputs (stall, fetched instruction, EX resolve)
// and the unit's outputs (pc, prediction, flushes, mispredict counter).
//   slave  : used by next_pc_predict (drives pc/pred*/flush*/mispredicts)
//   master : used by whatever drives fetch and resolve information
// Handshake: no valid/ready pair. resolveValid qualifies the resolve* fields
// for exactly the cycle it is high; every other signal is level-sampled at
// each rising clock edge.
interface next_pc_predict_if;
  logic        stall;
  logic [31:0] instruction;
  logic        resolveValid;
  logic [31:0] resolvePC;
  logic        resolveTaken;
  logic [31:0] resolveTarget;
  logic        resolvePredTaken;
  logic [31:0] resolvePredTarget;
  logic [31:0] pc;
  logic        predTaken;
  logic [31:0] predTarget;
  logic        flushID;
  logic        flushEX;
  logic [15:0] mispredicts;

  modport slave (
    input  stall, instruction, resolveValid, resolvePC, resolveTaken,
           resolveTarget, resolvePredTaken, resolvePredTarget,
    output pc, predTaken, predTarget, flushID, flushEX, mispredicts
  );

  modport master (
    output stall, instruction, resolveValid, resolvePC, resolveTaken,
           resolveTarget, resolvePredTaken, resolvePredTarget,
    input  pc, predTaken, predTarget, flushID, flushEX, mispredicts
  );
endinterface

// File: rtl/next_pc_predict.sv
// Fetch-stage PC unit with a direct-mapped BTB of saturating counters.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : next_pc_predict_if.slave (stall, instruction, resolve* in;
//           pc, predTaken, predTarget, flushID, flushEX, mispredicts out)
// J/JAL are decoded in IF and always predicted taken; everything else uses
// the BTB. A mispredict reported by EX redirects fetch (overriding stall)
// and squashes IF/ID and ID/EX in the same cycle.
module next_pc_predict #(
  parameter int          BTB_DEPTH = 16,
  parameter int          CTR_BITS  = 2,
  parameter logic [31:0] RESET_PC  = 32'h0000_3000
) (
  input logic              clk,
  input logic              reset,
  next_pc_predict_if.slave bus
);
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1 << (CTR_BITS - 1));

  // BTB storage; only valid bits and counters need a reset value.
  logic [BTB_DEPTH-1:0] btb_valid;
  logic [TAG_W-1:0]     btb_tag    [BTB_DEPTH];
  logic [31:0]          btb_target [BTB_DEPTH];
  logic [CTR_BITS-1:0]  btb_ctr    [BTB_DEPTH];

  logic [31:0]      pc_q;
  logic [15:0]      mis_q;
  logic [31:0]      pc_plus4;
  logic [31:0]      jump_addr;
  logic             is_j;
  logic [IDX_W-1:0] l_idx;
  logic             l_hit;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             mispredict;
  logic             upd_en;
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic             r_hit;

  // Fetch-side lookup and prediction
  always_comb begin
    pc_plus4  = pc_q + 32'd4;
    jump_addr = {pc_plus4[31:28], bus.instruction[25:0], 2'b00};
    is_j      = (bus.instruction[31:26] == 6'h02) ||
                (bus.instruction[31:26] == 6'h03);
    l_idx     = pc_q[IDX_W+1:2];
    l_hit     = btb_valid[l_idx] && (btb_tag[l_idx] == pc_q[31:IDX_W+2]);
    pred_taken  = 1'b0;
    pred_target = pc_plus4;
    if (is_j) begin
      pred_taken  = 1'b1;
      pred_target = jump_addr;
    end else if (l_hit && btb_ctr[l_idx][CTR_BITS-1]) begin
      pred_taken  = 1'b1;
      pred_target = btb_target[l_idx];
    end
  end

  // Resolve side: a taken branch with the wrong target is a mispredict too.
  always_comb begin
    upd_en     = bus.resolveValid && !reset;
    mispredict = upd_en &&
                 ((bus.resolveTaken != bus.resolvePredTaken) ||
                  (bus.resolveTaken &&
                   (bus.resolveTarget != bus.resolvePredTarget)));
    r_idx = bus.resolvePC[IDX_W+1:2];
    r_tag = bus.resolvePC[31:IDX_W+2];
    r_hit = btb_valid[r_idx] && (btb_tag[r_idx] == r_tag);
  end

  // PC register: reset > mispredict redirect > stall > prediction
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (mispredict) begin
      pc_q <= bus.resolveTaken ? bus.resolveTarget
                               : bus.resolvePC + 32'd4;
    end else if (!bus.stall) begin
      pc_q <= pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mis_q <= '0;
    end else if (mispredict) begin
      mis_q <= mis_q + 16'd1;
    end
  end

  // BTB valid/counter update. Writes land at the edge, so a lookup in the
  // same cycle always sees the old contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      btb_valid <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) btb_ctr[i] <= '0;
    end else if (upd_en) begin
      if (r_hit) begin
        if (bus.resolveTaken) begin
          if (btb_ctr[r_idx] != CTR_MAX) btb_ctr[r_idx] <= btb_ctr[r_idx] + 1'b1;
        end else begin
          if (btb_ctr[r_idx] != '0) btb_ctr[r_idx] <= btb_ctr[r_idx] - 1'b1;
        end
      end else if (bus.resolveTaken) begin
        btb_valid[r_idx] <= 1'b1;
        btb_ctr[r_idx]   <= CTR_INIT;
      end
    end
  end

  // Tag/target are meaningless while the valid bit is clear, so no reset.
  always_ff @(posedge clk) begin
    if (upd_en && bus.resolveTaken) begin
      btb_target[r_idx] <= bus.resolveTarget;
      if (!r_hit) btb_tag[r_idx] <= r_tag;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.predTaken   = pred_taken;
  assign bus.predTarget  = pred_target;
  assign bus.flushID     = mispredict;
  assign bus.flushEX     = mispredict;
  assign bus.mispredicts = mis_q;
endmodule

// File: tb/tb_next_pc_predict.sv
// Directed bench for next_pc_predict: the driver applies one vector per cycle
// and queues the hand-computed outputs; the monitor compares on the falling
// edge.
module tb_next_pc_predict;
  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] J3040 = 32'h0800_0C10;
  localparam logic [31:0] J3010 = 32'h0800_0C04;
  localparam int          W     = 83;

  logic clk = 1'b0;
  logic reset;
  next_pc_predict_if bus ();

  next_pc_predict dut (.clk(clk), .reset(reset), .bus(bus));

  // clock/reset
  always #5 clk = ~clk;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      chk("pc",          bus.pc,                  e[82:51]);
      chk("predTaken",   {31'd0, bus.predTaken},  {31'd0, e[50]});
      chk("predTarget",  bus.predTarget,          e[49:18]);
      chk("flushID",     {31'd0, bus.flushID},    {31'd0, e[17]});
      chk("flushEX",     {31'd0, bus.flushEX},    {31'd0, e[16]});
      chk("mispredicts", {16'd0, bus.mispredicts}, {16'd0, e[15:0]});
    end
  end

  // driver: one cycle of inputs plus the outputs expected in that cycle
  task automatic step(
    input logic rst, input logic stl, input logic [31:0] ins,
    input logic rv, input logic [31:0] rpc, input logic rt,
    input logic [31:0] rtgt, input logic rpt, input logic [31:0] rptgt,
    input logic [31:0] e_pc, input logic e_pt, input logic [31:0] e_ptgt,
    input logic e_fl, input logic [15:0] e_mis);
    @(posedge clk);
    #1;
    reset                 = rst;
    bus.stall             = stl;
    bus.instruction       = ins;
    bus.resolveValid      = rv;
    bus.resolvePC         = rpc;
    bus.resolveTaken      = rt;
    bus.resolveTarget     = rtgt;
    bus.resolvePredTaken  = rpt;
    bus.resolvePredTarget = rptgt;
    exp_q.push_back({e_pc, e_pt, e_ptgt, e_fl, e_fl, e_mis});
  endtask

  initial begin
    reset                 = 1'b1;
    bus.stall             = 1'b0;
    bus.instruction       = NOP;
    bus.resolveValid      = 1'b0;
    bus.resolvePC         = '0;
    bus.resolveTaken      = 1'b0;
    bus.resolveTarget     = '0;
    bus.resolvePredTaken  = 1'b0;
    bus.resolvePredTarget = '0;

    //   rst stl ins    rv rpc           rt rtgt          rpt rptgt        | pc            pt ptgt          fl mis
    // reset and release
    step(1, 0, NOP,   0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h3000,     0, 32'h3004,     0, 0);
    step(1, 0, NOP,   0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h3000,     0, 32'h3004,     0, 0);
    step(0, 0, NOP,   0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h3000,     0, 32'h3004,     0, 0);
    step(0, 0, NOP,   0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h3004,     0, 32'h3008,     0, 0);
    // J decoded in IF
    step(0, 0, J3040, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h3008,     1, 32'h3040,     0, 0);
    // cold-BTB taken mispredict
    step(0, 0, NOP,   1, 32'h3010,     1, 32'h3100,     0, 32'h3014,     32'h3040,     0, 32'h3044,     1, 0);
    step(0, 0, J3010, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h3100,     1, 32'h3010,     0, 1);
    // BTB hit predicts taken; same-cycle not-taken resolve (old contents seen)
    step(0, 0, NOP,   1, 32'h3010,     0, 32'h3014,     1, 32'h3100,     32'h3010,     1, 32'h3100,     1, 1);
    step(0, 0, J3010, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h3014,     1, 32'h3010,     0, 2);
    // ctr 1: not taken; correctly predicted not-taken resolve drops ctr to 0
    step(0, 0, NOP,   1, 32'h3010,     0, 32'h3014,     0, 32'h3014,     32'h3010,     0, 32'h3014,     0, 2);
    // taken, correctly predicted: ctr 0 -> 1, still predicts not taken
    step(0, 0, J3010, 1, 32'h3010,     1, 32'h3100,     1, 32'h3100,     32'h3014,     1, 32'h3010,     0, 2);
    step(0, 0, NOP,   0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h3010,     0, 32'h3014,     0, 2);
    // stall with mispredict: redirect wins
    step(0, 1, NOP,   1, 32'h3020,     1, 32'h3400,     0, 32'h3024,     32'h3014,     0, 32'h3018,     1, 2);
    // stall alone for 3 cycles while a resolve allocates the entry for pc
    step(0, 1, NOP,   1, 32'h3400,     1, 32'h3500,     1, 32'h3500,     32'h3400,     0, 32'h3404,     0, 3);
    step(0, 1, NOP,   0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h3400,     1, 32'h3500,     0, 3);
    step(0, 1, NOP,   0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h3400,     1, 32'h3500,     0, 3);
    step(0, 0, NOP,   0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h3400,     1, 32'h3500,     0, 3);
    // raise 0x3010 ctr to 2, then alias it out with 0x3050
    step(0, 0, J3010, 1, 32'h3010,     1, 32'h3100,     1, 32'h3100,     32'h3500,     1, 32'h3010,     0, 3);
    step(0, 1, NOP,   1, 32'h3050,     1, 32'h3200,     1, 32'h3200,     32'h3010,     1, 32'h3100,     0, 3);
    step(0, 0, NOP,   0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h3010,     0, 32'h3014,     0, 3);
    // not-taken redirect to the top of memory; pc+4 wraps to 0
    step(0, 0, NOP,   1, 32'hFFFF_FFF8, 0, 32'h0,       1, 32'h1234,     32'h3014,     0, 32'h3018,     1, 3);
    step(0, 0, NOP,   0, 32'h0,        0, 32'h0,        0, 32'h0,        32'hFFFF_FFFC, 0, 32'h0,        0, 4);
    // taken with wrong predicted target
    step(0, 0, NOP,   1, 32'h0,        1, 32'h40,       1, 32'h44,       32'h0,        0, 32'h4,        1, 4);
    step(0, 0, NOP,   0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h40,       0, 32'h44,       0, 5);
    // reset masks a concurrent mispredict
    step(1, 0, NOP,   1, 32'h44,       1, 32'h80,       0, 32'h48,       32'h44,       0, 32'h48,       0, 5);
    step(0, 0, NOP,   0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h3000,     0, 32'h3004,     0, 0);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/next_pc_predict.md
Name: next_pc_predict

Overview:
Fetch-stage program-counter unit with branch prediction. It owns the PC register and decodes J/JAL in IF. It predicts conditional branches and jump-register targets from a direct-mapped branch target buffer (BTB) with saturating counters. It redirects fetch and raises flushID/flushEX when EX resolves a mispredicted control instruction.

Parameters:
BTB_DEPTH, 16, number of BTB entries; power of two, >= 2; IDX_W = log2(BTB_DEPTH)
CTR_BITS, 2, saturating-counter width, 1..4; predict taken when counter MSB = 1
RESET_PC, 32'h0000_3000, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
stall  in  1  hold PC (IF stall)
instruction  in  32  instruction fetched at pc
resolveValid  in  1  EX resolves a branch/jr this cycle
resolvePC  in  32  PC of the resolved instruction
resolveTaken  in  1  actual outcome (jr always 1)
resolveTarget  in  32  actual target
resolvePredTaken  in  1  prediction carried down the pipe with the instruction
resolvePredTarget  in  32  predicted target carried down the pipe
pc  out  32  current fetch PC, registered
predTaken  out  1  prediction for pc, combinational
predTarget  out  32  predicted next PC for pc, combinational
flushID  out  1  squash IF/ID, combinational
flushEX  out  1  squash ID/EX, combinational
mispredicts  out  16  mispredict event counter, registered

Behaviour:
- Reset (sync, active-high): pc = RESET_PC; mispredicts = 0; all BTB valid bits = 0; counters = 0; flushID = flushEX = 0 while reset is high.
- BTB entry fields: valid, tag = addr[31:IDX_W+2], target[31:0], ctr[CTR_BITS-1:0]. Index = addr[IDX_W+1:2].
- Lookup is combinational on pc. hit = valid && tag match.
- jumpAddr = {(pc+4)[31:28], instruction[25:0], 2'b00}.
- isJ = opcode (instruction[31:26]) is J (6'h02) or JAL (6'h03).
- Prediction:
  - isJ: predTaken = 1, predTarget = jumpAddr.
  - else hit && ctr MSB: predTaken = 1, predTarget = BTB target.
  - else predTaken = 0, predTarget = pc + 4.
- mispredict = resolveValid && !reset && (resolveTaken != resolvePredTaken || (resolveTaken && resolveTarget != resolvePredTarget)).
- Next-PC priority, registered at clock edge:
  1. reset -> RESET_PC.
  2. mispredict -> resolveTaken ? resolveTarget : resolvePC + 4. Overrides stall.
  3. stall -> hold pc.
  4. else -> predTarget.
- flushID = flushEX = mispredict. Both are high for exactly the cycle the mispredict is presented.
- mispredicts increments on each mispredict edge and wraps from 16'hFFFF to 0.
- BTB update at the clock edge when resolveValid && !reset, at index of resolvePC. Update happens regardless of stall.
  - Hit, taken: ctr saturating +1 (max 2^CTR_BITS-1); target = resolveTarget.
  - Hit, not taken: ctr saturating -1 (min 0); target unchanged.
  - Miss, taken: allocate/replace: valid = 1, tag, target = resolveTarget, ctr = 1 << (CTR_BITS-1).
  - Miss, not taken: no change.
- Same-cycle lookup and update to the same index: lookup sees the pre-update contents (read-before-write).
- J/JAL are never resolved through this port and are never written into the BTB.
- All arithmetic is 32-bit modulo. pc + 4 wraps 32'hFFFF_FFFC -> 0.

Test Plan:
1. reset high 2 cycles with defaults -> pc = 0x00003000, mispredicts = 0, flushes 0; release, no stall -> pc = 0x00003004 next cycle.
2. pc = 0x00003008, instruction = 0x08000C10 (J) -> predTaken = 1, predTarget = 0x00003040, next pc = 0x00003040, no flush.
3. Cold BTB: resolve pc 0x3010, taken, target 0x3100, predTaken = 0 -> next pc 0x3100; flushID/EX high one cycle; mispredicts = 1; entry ctr = 2. Later fetch at 0x3010 -> predTaken = 1, next pc 0x3100.
4. Continuing from 3: resolve 0x3010 not taken with predTaken = 1 -> redirect 0x3014, flush, ctr = 1. Next fetch at 0x3010 predicts 0x3014. Second not-taken resolve with predTaken = 0 -> no flush, ctr = 0.
5. stall = 1 together with a mispredict -> redirect target taken, flush high. stall = 1 alone for 3 cycles -> pc held, while a concurrent resolve still updates the BTB.
6. Aliasing, BTB_DEPTH = 16: entry for 0x3010 present; resolve 0x3050 (same index 4) taken, target 0x3200 -> entry replaced. Fetch at 0x3010 now misses and predicts 0x3014.
